div_ctrl: RTL and testbench



---
 rtl/div_ctrl_if.sv | 23 ++
 rtl/div_ctrl.sv | 156 +++++++++++++++
 tb/tb_div_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/div_ctrl_if.sv
// EX-stage <-> divide sequencer handshake: operands and control in, {rem, quot} and stall out.
interface div_ctrl_if #(
   parameter int unsigned WIDTH = 32
);
   logic                 start_i;
   logic                 signed_div_i;
   logic [WIDTH-1:0]     opdata1_i;
   logic [WIDTH-1:0]     opdata2_i;
   logic                 annul_i;
   logic [2*WIDTH-1:0]   result_o;
   logic                 ready_o;
   logic                 stallreq_o;

   modport master (
      output start_i, signed_div_i, opdata1_i, opdata2_i, annul_i,
      input  result_o, ready_o, stallreq_o
   );

   modport slave (
      input  start_i, signed_div_i, opdata1_i, opdata2_i, annul_i,
      output result_o, ready_o, stallreq_o
   );
endinterface

// File: rtl/div_ctrl.sv
// Multi-cycle restoring divider for EX: one shift/subtract step per cycle, stalls the
// pipeline while busy and presents {remainder, quotient} for the HI/LO write.
module div_ctrl #(
   parameter int unsigned WIDTH = 32
) (
   input logic       clk,
   input logic       rst,
   div_ctrl_if.slave bus
);
   localparam int unsigned CW = $clog2(WIDTH) + 1;
   localparam int unsigned RW = 2 * WIDTH;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_BYZERO = 2'd1,
      S_ON     = 2'd2,
      S_END    = 2'd3
   } state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic [WIDTH-1:0] quot, quot_nxt;
   logic [WIDTH-1:0] rem, rem_nxt;
   logic [WIDTH-1:0] dvsr, dvsr_nxt;
   logic             q_neg, q_neg_nxt;
   logic             r_neg, r_neg_nxt;
   logic [RW-1:0]    result, result_nxt;
   logic             ready, ready_nxt;

   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] step_rem, step_quot;
   logic [WIDTH-1:0] fix_rem, fix_quot;
   logic [WIDTH-1:0] abs_a, abs_b;
   logic             neg_a, neg_b;
   logic             last_step;

   // One restoring step; the bit shifted out of rem is kept so large divisors stay exact.
   always_comb begin
      rem_sh = {rem, quot[WIDTH-1]};
      diff   = rem_sh - {1'b0, dvsr};
      if (!diff[WIDTH]) begin
         step_rem  = diff[WIDTH-1:0];
         step_quot = {quot[WIDTH-2:0], 1'b1};
      end else begin
         step_rem  = rem_sh[WIDTH-1:0];
         step_quot = {quot[WIDTH-2:0], 1'b0};
      end
      fix_quot  = q_neg ? -step_quot : step_quot;
      fix_rem   = r_neg ? -step_rem : step_rem;
      last_step = (cnt == CW'(WIDTH - 1));
   end

   // Operand magnitudes for the signed case
   always_comb begin
      neg_a = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
      neg_b = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
      abs_a = neg_a ? -bus.opdata1_i : bus.opdata1_i;
      abs_b = neg_b ? -bus.opdata2_i : bus.opdata2_i;
   end

   // Next-state and datapath update
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      quot_nxt   = quot;
      rem_nxt    = rem;
      dvsr_nxt   = dvsr;
      q_neg_nxt  = q_neg;
      r_neg_nxt  = r_neg;
      result_nxt = result;
      ready_nxt  = ready;

      case (state)
         S_IDLE: begin
            result_nxt = '0;
            ready_nxt  = 1'b0;
            if (bus.start_i && !bus.annul_i) begin
               if (bus.opdata2_i == '0) begin
                  state_nxt = S_BYZERO;
               end else begin
                  state_nxt = S_ON;
                  quot_nxt  = abs_a;
                  dvsr_nxt  = abs_b;
                  rem_nxt   = '0;
                  cnt_nxt   = '0;
                  q_neg_nxt = neg_a ^ neg_b;
                  r_neg_nxt = neg_a;
               end
            end
         end
         S_BYZERO: begin
            state_nxt  = S_END;
            result_nxt = '0;
            ready_nxt  = 1'b1;
         end
         S_ON: begin
            quot_nxt = step_quot;
            rem_nxt  = step_rem;
            cnt_nxt  = cnt + CW'(1);
            if (last_step) begin
               state_nxt  = S_END;
               result_nxt = {fix_rem, fix_quot};
               ready_nxt  = 1'b1;
            end
         end
         S_END: begin
            if (!bus.start_i) begin
               state_nxt  = S_IDLE;
               result_nxt = '0;
               ready_nxt  = 1'b0;
            end
         end
         default: begin
            state_nxt  = S_IDLE;
            result_nxt = '0;
            ready_nxt  = 1'b0;
         end
      endcase

      // Flush abandons the operation; its result is never presented
      if (bus.annul_i && state != S_IDLE) begin
         state_nxt  = S_IDLE;
         result_nxt = '0;
         ready_nxt  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= S_IDLE;
         cnt    <= '0;
         quot   <= '0;
         rem    <= '0;
         dvsr   <= '0;
         q_neg  <= 1'b0;
         r_neg  <= 1'b0;
         result <= '0;
         ready  <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         quot   <= quot_nxt;
         rem    <= rem_nxt;
         dvsr   <= dvsr_nxt;
         q_neg  <= q_neg_nxt;
         r_neg  <= r_neg_nxt;
         result <= result_nxt;
         ready  <= ready_nxt;
      end
   end

   assign bus.result_o   = result;
   assign bus.ready_o    = ready;
   assign bus.stallreq_o = bus.start_i & ~bus.annul_i & (state != S_END);
endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: arithmetic reference model plus directed vectors.
module tb_div_ctrl;
   localparam int unsigned WIDTH = 32;

   logic clk = 1'b0;
   logic rst = 1'b0;

   div_ctrl_if #(.WIDTH(WIDTH)) bus ();

   div_ctrl #(.WIDTH(WIDTH)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   // Reference model state: busy countdown, pending answer, presented answer
   bit          m_ready = 1'b0;
   logic [63:0] m_res   = '0;
   logic [63:0] m_pend  = '0;
   int          m_left  = 0;

   function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                           input logic sgn);
      longint sa, sb, q, r;
      if (b == 32'd0) return 64'd0;
      if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'd0, a});
         sb = longint'({32'd0, b});
      end
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic s, input logic sg, input logic [31:0] a,
                        input logic [31:0] b, input logic an);
      bus.start_i      = s;
      bus.signed_div_i = sg;
      bus.opdata1_i    = a;
      bus.opdata2_i    = b;
      bus.annul_i      = an;
   endtask

   // Model: WIDTH busy cycles (1 for divide by zero), then result held while start stays high
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_ready <= 1'b0;
         m_res   <= '0;
         m_pend  <= '0;
         m_left  <= 0;
      end else if (m_ready) begin
         if (bus.annul_i || !bus.start_i) begin
            m_ready <= 1'b0;
            m_res   <= '0;
         end
      end else if (m_left > 0) begin
         if (bus.annul_i) begin
            m_left <= 0;
         end else begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
               m_ready <= 1'b1;
               m_res   <= m_pend;
            end
         end
      end else if (bus.start_i && !bus.annul_i) begin
         m_pend <= ref_div(bus.opdata1_i, bus.opdata2_i, bus.signed_div_i);
         m_left <= (bus.opdata2_i == 32'd0) ? 1 : int'(WIDTH);
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("ready_o", 64'(bus.ready_o), 64'(m_ready));
         chk("result_o", bus.result_o, m_res);
         chk("stallreq_o", 64'(bus.stallreq_o),
             64'(bus.start_i & ~bus.annul_i & ~m_ready));
      end
   end

   task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int lat, input string name);
      int          stalls = 0;
      int          cyc    = -1;
      logic [63:0] got    = '0;
      @(posedge clk);
      #1;
      drive(1'b1, sgn, a, b, 1'b0);
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (bus.stallreq_o) stalls++;
         if (bus.ready_o) begin
            cyc = c;
            got = bus.result_o;
            break;
         end
         if (c == 1) begin
            bus.opdata1_i = $urandom;
            bus.opdata2_i = $urandom;
         end
      end
      chk({name, " latency"}, 64'(cyc), 64'(lat));
      chk({name, " result"}, got, exp);
      chk({name, " stall cycles"}, 64'(stalls), 64'(lat));
      @(posedge clk);
      #1;
      @(negedge clk);
      chk({name, " hold ready"}, 64'(bus.ready_o), 64'd1);
      chk({name, " hold result"}, bus.result_o, exp);
      @(posedge clk);
      #1;
      bus.start_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int rdy_seen;
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      cmp_en = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset ready_o", 64'(bus.ready_o), 64'd0);
      chk("reset result_o", bus.result_o, 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;

      run_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, "divu 100/7");
      run_div(1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 33, "div -7/2");
      run_div(1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33, "div 7/-2");
      run_div(1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 64'hFFFFFFFF_00000003, 33, "div -7/-2");
      run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33, "div wrap");
      run_div(1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, 33, "divu max/1");
      run_div(1'b0, 32'hFFFFFFFF, 32'h80000001, 64'h7FFFFFFE_00000001, 33, "divu big divisor");
      run_div(1'b1, 32'hFFFFFF9C, 32'd7, 64'hFFFFFFFE_FFFFFFF2, 33, "div -100/7");
      run_div(1'b0, 32'd5, 32'd0, 64'd0, 2, "div by zero");

      // Flush in cycle 10 with start still high
      @(posedge clk);
      #1;
      drive(1'b1, 1'b0, 32'd100, 32'd7, 1'b0);
      repeat (10) @(posedge clk);
      #1;
      bus.annul_i = 1'b1;
      @(negedge clk);
      chk("annul stall", 64'(bus.stallreq_o), 64'd0);
      @(posedge clk);
      #1;
      bus.start_i = 1'b0;
      bus.annul_i = 1'b0;
      rdy_seen = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bus.ready_o) rdy_seen++;
      end
      chk("annul no ready", 64'(rdy_seen), 64'd0);
      run_div(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33, "divu 9/3 after annul");

      // Reset in cycle 15 of a division, between clock edges
      @(posedge clk);
      #1;
      drive(1'b1, 1'b0, 32'd100, 32'd7, 1'b0);
      repeat (15) @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      chk("mid-on reset ready_o", 64'(bus.ready_o), 64'd0);
      chk("mid-on reset result_o", bus.result_o, 64'd0);
      bus.start_i = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      run_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, "divu 100/7 after reset");

      // Reset while the result is being presented
      @(posedge clk);
      #1;
      drive(1'b1, 1'b0, 32'd100, 32'd7, 1'b0);
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bus.ready_o) break;
      end
      chk("end result before reset", bus.result_o, 64'h00000002_0000000E);
      #2;
      rst = 1'b0;
      #1;
      chk("end reset ready_o", 64'(bus.ready_o), 64'd0);
      chk("end reset result_o", bus.result_o, 64'd0);
      bus.start_i = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
